// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised synchronous up/down modulo counter with
// clear, parallel load, dual enable (ENT/ENP), combinational ripple carry
// and a registered wrap pulse.
// Optional feature macro: PARAM_UPDOWN_COUNTER_SAT_EN -- when defined the
// counter saturates at the terminal state instead of wrapping.
module param_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR_L,
    input  logic             LD_L,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    // Largest legal count value; loads above it are clamped here.
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 64'd1);

    logic             at_top;
    logic             at_bottom;
    logic             at_term;
    logic             count_en;
    logic             d_in_range;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    // Terminal-state decode for the current direction.
    always_comb begin
        at_top     = (Q == Q_MAX);
        at_bottom  = (Q == '0);
        at_term    = UP ? at_top : at_bottom;
        count_en   = ENT & ENP;
        d_in_range = (64'(D) < MODULUS);
    end

    // Ripple carry follows Q, ENT and UP within the same cycle.
    assign RCO = ENT & at_term;

    // Next-state selection in priority order: clear, load, count, hold.
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (!CLR_L) begin
            q_next = '0;
        end else if (!LD_L) begin
            q_next = d_in_range ? D : Q_MAX;
        end else if (count_en) begin
            if (at_term) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                q_next    = Q;
                wrap_next = 1'b0;
`else
                q_next    = UP ? '0 : Q_MAX;
                wrap_next = 1'b1;
`endif
            end else begin
                q_next = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
            end
        end
    end

    // Count and wrap registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else begin
            Q    <= q_next;
            WRAP <= wrap_next;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, MODULUS=10):
// directed scenarios with literal expectations, a two-stage cascade, and
// randomized stimulus compared every cycle against an arithmetic model.
module tb_param_updown_counter;

    localparam int unsigned WIDTH = 4;
    localparam int          MOD   = 10;

    logic             CLK = 1'b0;
    logic             RST, CLR_L, LD_L, ENT, ENP, UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO, WRAP;

    logic             cas_enp;
    logic [WIDTH-1:0] c0_q, c1_q;
    logic             c0_rco, c1_rco, c0_wrap, c1_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int m_q    = 0;
    int m_wrap = 0;

    always #5 CLK = ~CLK;

    param_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
        .CLK(CLK), .RST(RST), .CLR_L(CLR_L), .LD_L(LD_L), .ENT(ENT),
        .ENP(ENP), .UP(UP), .D(D), .Q(Q), .RCO(RCO), .WRAP(WRAP)
    );

    param_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) cas0 (
        .CLK(CLK), .RST(RST), .CLR_L(1'b1), .LD_L(1'b1), .ENT(1'b1),
        .ENP(cas_enp), .UP(1'b1), .D('0), .Q(c0_q), .RCO(c0_rco), .WRAP(c0_wrap)
    );

    param_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) cas1 (
        .CLK(CLK), .RST(RST), .CLR_L(1'b1), .LD_L(1'b1), .ENT(c0_rco),
        .ENP(cas_enp), .UP(1'b1), .D('0), .Q(c1_q), .RCO(c1_rco), .WRAP(c1_wrap)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rco(input int q, input logic ent, input logic up);
        if (!ent) return 0;
        return up ? int'(q == MOD - 1) : int'(q == 0);
    endfunction

    // Behavioural model: plain modular arithmetic on the sampled inputs.
    always @(posedge CLK) begin
        if (RST === 1'b1 || CLR_L === 1'b0) begin
            m_q = 0; m_wrap = 0;
        end else if (LD_L === 1'b0) begin
            m_q = (int'(D) < MOD) ? int'(D) : MOD - 1;
            m_wrap = 0;
        end else if (ENT && ENP) begin
            if (UP) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                m_wrap = 0;
                if (m_q < MOD - 1) m_q = m_q + 1;
`else
                m_wrap = int'(m_q == MOD - 1);
                m_q    = (m_q + 1) % MOD;
`endif
            end else begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                m_wrap = 0;
                if (m_q > 0) m_q = m_q - 1;
`else
                m_wrap = int'(m_q == 0);
                m_q    = (m_q + MOD - 1) % MOD;
`endif
            end
        end else begin
            m_wrap = 0;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_q", longint'(Q), longint'(m_q));
            chk("model_wrap", longint'(WRAP), longint'(m_wrap));
            chk("model_rco", longint'(RCO), longint'(model_rco(m_q, ENT, UP)));
        end
    end

    // Advance one clock edge and settle just after the following negedge.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int exp_q;
        int wrap_cnt;

        RST = 1'b1; CLR_L = 1'b1; LD_L = 1'b0; D = 4'd7;
        ENT = 1'b1; ENP = 1'b1; UP = 1'b0; cas_enp = 1'b0;

        // Reset held for two edges, load also asserted
        repeat (2) @(posedge CLK);
        step();
        chk("reset_q", longint'(Q), 0);
        chk("reset_wrap", longint'(WRAP), 0);
        chk("reset_rco_down", longint'(RCO), 1);
        chk_en = 1'b1;

        // Up count through the wrap
        RST = 1'b0; LD_L = 1'b1; UP = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
            exp_q = (i < 9) ? i : 9;
            chk("up_wrap", longint'(WRAP), 0);
`else
            exp_q = i % 10;
            chk("up_wrap", longint'(WRAP), longint'(i == 10));
`endif
            chk("up_q", longint'(Q), longint'(exp_q));
            chk("up_rco", longint'(RCO), longint'(exp_q == 9));
        end

        // Load above the modulus clamps to 9
        LD_L = 1'b0; D = 4'd12;
        step();
        chk("load_clamp_q", longint'(Q), 9);

        // Down count through the wrap
        LD_L = 1'b1; UP = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
            exp_q = (i <= 9) ? 9 - i : 0;
            chk("down_wrap", longint'(WRAP), 0);
`else
            exp_q = (i <= 9) ? 9 - i : 9;
            chk("down_wrap", longint'(WRAP), longint'(i == 10));
`endif
            chk("down_q", longint'(Q), longint'(exp_q));
        end

        // Clear and load together: clear wins
        CLR_L = 1'b0; LD_L = 1'b0; D = 4'd5;
        step();
        chk("clr_over_load_q", longint'(Q), 0);

        // Load 9, then ENP low holds at the terminal state
        CLR_L = 1'b1; LD_L = 1'b0; D = 4'd9;
        step();
        chk("load9_q", longint'(Q), 9);
        LD_L = 1'b1; UP = 1'b1; ENT = 1'b1; ENP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q", longint'(Q), 9);
            chk("hold_rco", longint'(RCO), 1);
            chk("hold_wrap", longint'(WRAP), 0);
        end
        ENT = 1'b0;
        #1;
        chk("ent_low_rco", longint'(RCO), 0);

        // Direction change mid-count: 5 up-toggled-to-down gives 4
        LD_L = 1'b0; D = 4'd5;
        step();
        LD_L = 1'b1; ENT = 1'b1; ENP = 1'b1; UP = 1'b0;
        step();
        chk("dir_change_q", longint'(Q), 4);
        ENP = 1'b0;

        // Two-stage cascade for 100 enabled edges
        wrap_cnt = 0;
        cas_enp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (c1_wrap) wrap_cnt++;
        end
        cas_enp = 1'b0;
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk("cascade_q0", longint'(c0_q), 9);
        chk("cascade_q1", longint'(c1_q), 9);
        chk("cascade_wraps", longint'(wrap_cnt), 0);
`else
        chk("cascade_q0", longint'(c0_q), 0);
        chk("cascade_q1", longint'(c1_q), 0);
        chk("cascade_wraps", longint'(wrap_cnt), 1);
`endif

        // Randomized traffic checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            RST   = ($urandom_range(0, 63) == 0);
            CLR_L = ($urandom_range(0, 31) != 0);
            LD_L  = ($urandom_range(0, 11) != 0);
            ENT   = ($urandom_range(0, 7) != 0);
            ENP   = ($urandom_range(0, 7) != 0);
            UP    = ($urandom_range(0, 5) != 0) ? UP : ~UP;
            D     = WIDTH'($urandom_range(0, 15));
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
